// File: rtl/mux_8x16_arbiter.sv
// Round-robin arbiter for the shared 8-input, 16-bit result bus.
// Picks one owner at a time, drives the mux select and a one-hot grant,
// preempts an owner after MAX_HOLD cycles when others wait, and inserts
// one idle gap cycle between successive owners.
module mux_8x16_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [2:0] s,
    output logic [7:0] gnt,
    output logic       valid,
    output logic [7:0] hold_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Tenure length after which a waiting requester forces a handover
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    state_t     r_state;
    logic [2:0] r_s;
    logic [7:0] r_gnt;
    logic       r_valid;
    logic [7:0] r_hold_cnt;
    logic [2:0] r_last;

    state_t     w_state_nxt;
    logic [2:0] w_s_nxt;
    logic [7:0] w_gnt_nxt;
    logic       w_valid_nxt;
    logic [7:0] w_hold_nxt;
    logic [2:0] w_last_nxt;

    logic [2:0] w_idx;
    logic [2:0] w_winner;
    logic       w_others;
    logic       w_preempt;

    // Round-robin search: scan downward so the closest index after r_last wins
    always_comb begin
        w_idx    = r_last;
        w_winner = r_last;
        for (int k = 8; k >= 1; k--) begin
            w_idx = r_last + k[2:0];
            if (req[w_idx]) begin
                w_winner = w_idx;
            end
        end
    end

    // Another requester is waiting, and the owner has used up its tenure
    always_comb begin
        w_others  = |(req & ~(8'b1 << r_s));
        w_preempt = (r_hold_cnt >= HOLD_LIM) && w_others;
    end

    // Next-state and registered-output values
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_gnt_nxt   = 8'h00;
        w_valid_nxt = 1'b0;
        w_hold_nxt  = 8'h00;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE, GAP: begin
                if (|req) begin
                    w_state_nxt = GRANT;
                    w_s_nxt     = w_winner;
                    w_gnt_nxt   = 8'b1 << w_winner;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = w_winner;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (!req[r_s] || w_preempt) begin
                    w_state_nxt = GAP;
                end else begin
                    w_gnt_nxt   = r_gnt;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = (r_hold_cnt == 8'hFF) ? 8'hFF : r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; last=7 on reset so requester 0 is searched first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_s        <= 3'd0;
            r_gnt      <= 8'h00;
            r_valid    <= 1'b0;
            r_hold_cnt <= 8'h00;
            r_last     <= 3'd7;
        end else begin
            r_state    <= w_state_nxt;
            r_s        <= w_s_nxt;
            r_gnt      <= w_gnt_nxt;
            r_valid    <= w_valid_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_last     <= w_last_nxt;
        end
    end

    assign s        = r_s;
    assign gnt      = r_gnt;
    assign valid    = r_valid;
    assign hold_cnt = r_hold_cnt;

endmodule

// File: tb/tb_mux_8x16_arbiter.sv
// Directed bench for mux_8x16_arbiter with MAX_HOLD=16, followed by a
// randomized request phase checked against the arbiter's invariants.
module tb_mux_8x16_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [2:0] s;
    logic [7:0] gnt;
    logic       valid;
    logic [7:0] hold_cnt;

    int n_cmp;
    int n_err;

    mux_8x16_arbiter #(.MAX_HOLD(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .s        (s),
        .gnt      (gnt),
        .valid    (valid),
        .hold_cnt (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_s,
                           input logic e_valid, input logic [7:0] e_hold);
        chk({tag, "_gnt"}, 32'(gnt), 32'(e_gnt));
        chk({tag, "_s"}, 32'(s), 32'(e_s));
        chk({tag, "_valid"}, 32'(valid), 32'(e_valid));
        chk({tag, "_hold"}, 32'(hold_cnt), 32'(e_hold));
    endtask

    int         wait_c [8];
    int         max_wait;
    logic       prev_valid;
    logic [2:0] prev_s;
    logic [7:0] nreq;
    int         exp_hold;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = 8'h00;
        #2;
        chk_out("reset", 8'h00, 3'd0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle with no requests
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("idle", 8'h00, 3'd0, 1'b0, 8'h00);
        end

        // Two requesters, owners release voluntarily
        req = 8'h81;
        step();
        chk_out("two_g0", 8'h01, 3'd0, 1'b1, 8'h00);
        step();
        chk_out("two_g0b", 8'h01, 3'd0, 1'b1, 8'h01);
        req = 8'h80;
        step();
        chk_out("two_gap1", 8'h00, 3'd0, 1'b0, 8'h00);
        step();
        chk_out("two_g7", 8'h80, 3'd7, 1'b1, 8'h00);
        req = 8'h00;
        step();
        chk_out("two_gap2", 8'h00, 3'd7, 1'b0, 8'h00);
        step();
        chk_out("two_idle", 8'h00, 3'd7, 1'b0, 8'h00);

        // All requesting: rotation 0..7,0 with 16-cycle tenures and one gap each
        req = 8'hFF;
        for (int t = 0; t < 9; t++) begin
            for (int c = 0; c < 16; c++) begin
                step();
                chk("rr_gnt", 32'(gnt), 32'(8'b1 << (t % 8)));
                chk("rr_hold", 32'(hold_cnt), 32'(c));
                if (c == 0) chk("rr_s", 32'(s), 32'(t % 8));
            end
            step();
            chk("rr_gap_valid", 32'(valid), 32'h0);
            chk("rr_gap_gnt", 32'(gnt), 32'h0);
        end
        req = 8'h00;
        step();
        chk_out("rr_idle", 8'h00, 3'd0, 1'b0, 8'h00);

        // Lone requester: never preempted, counter saturates at 255
        req = 8'h04;
        for (int i = 0; i < 300; i++) begin
            step();
            exp_hold = (i > 255) ? 255 : i;
            chk("lone_gnt", 32'(gnt), 32'h04);
            chk("lone_hold", 32'(hold_cnt), 32'(exp_hold));
        end
        chk_out("lone_end", 8'h04, 3'd2, 1'b1, 8'hFF);

        // Owner drops while another rises in the same cycle: handled as release
        req = 8'h08;
        step();
        chk_out("swap_gap", 8'h00, 3'd2, 1'b0, 8'h00);
        step();
        chk_out("swap_g3", 8'h08, 3'd3, 1'b1, 8'h00);
        req = 8'h00;
        step();
        step();
        chk_out("swap_idle", 8'h00, 3'd3, 1'b0, 8'h00);

        // Reset in IDLE, then owner 2 mid-tenure hit by asynchronous reset
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = 8'h0C;
        step();
        chk_out("rst_g2", 8'h04, 3'd2, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) step();
        chk_out("rst_h5", 8'h04, 3'd2, 1'b1, 8'h05);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst_async", 8'h00, 3'd0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk_out("rst_regrant", 8'h04, 3'd2, 1'b1, 8'h00);

        // Random requests holding until granted; check invariants and starvation
        for (int i = 0; i < 8; i++) wait_c[i] = 0;
        max_wait   = 0;
        prev_valid = valid;
        prev_s     = s;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            nreq = req;
            for (int i = 0; i < 8; i++) begin
                if (gnt[i] && req[i] && $urandom_range(0, 19) == 0) nreq[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0) nreq[i] = 1'b1;
            end
            req = nreq;
            step();
            chk("rnd_onehot", 32'($onehot0(gnt)), 32'h1);
            chk("rnd_gnt_valid", 32'(gnt != 8'h00), 32'(valid));
            if (valid) chk("rnd_gnt_s", 32'(gnt), 32'(8'b1 << s));
            if (prev_valid && valid) chk("rnd_s_stable", 32'(s), 32'(prev_s));
            prev_valid = valid;
            prev_s     = s;
            for (int i = 0; i < 8; i++) begin
                if (gnt[i] || !req[i]) wait_c[i] = 0;
                else wait_c[i]++;
                if (wait_c[i] > max_wait) max_wait = wait_c[i];
            end
        end
        chk("rnd_starve", 32'(max_wait <= 8 * 17), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
